// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read-channel arbiter.
package mem_arb_pkg;

  localparam int TID_WIDTH = 2;
  localparam int MAX_TX    = 1 << TID_WIDTH;

  typedef logic [TID_WIDTH-1:0] tid_t;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;
  localparam int REQ_PTW    = 2;

  function automatic int max_tx(input int tid_width);
    return 1 << tid_width;
  endfunction

endpackage

// File: rtl/rr_arbiter_ptr.sv
// Round-robin picker: combinational winner search from a registered pointer.
// Pointer advances past the winner only when the grant is enabled.
module rr_arbiter_ptr #(
  parameter  int NrReq = 3,
  localparam int IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NrReq-1:0] req,
  input  logic             en,
  output logic [NrReq-1:0] gnt,
  output logic [IdxW-1:0]  idx,
  output logic             any
);

  logic [IdxW-1:0] ptr;
  logic [IdxW:0]   cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < NrReq; i++) begin
      cand = {1'b0, ptr} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NrReq)) cand = cand - (IdxW+1)'(NrReq);
      if (!any && req[cand[IdxW-1:0]]) begin
        any = 1'b1;
        idx = cand[IdxW-1:0];
      end
    end
    gnt = (any && en) ? (NrReq'(1) << idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= (idx == IdxW'(NrReq-1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one memory read channel among NrReq requesters with TID allocation and
// out-of-order response routing; 1-cycle request latency, slot held until mem ready.
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NrReq     = 3,
  parameter int AddrWidth = 56,
  parameter int DataWidth = 64,
  parameter int TidWidth  = TID_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NrReq-1:0]           req_valid_i,
  output logic [NrReq-1:0]           req_ready_o,
  input  logic [NrReq*AddrWidth-1:0] req_addr_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [AddrWidth-1:0]       mem_req_addr_o,
  output logic [TidWidth-1:0]        mem_req_tid_o,
  input  logic                       mem_rsp_valid_i,
  input  logic [TidWidth-1:0]        mem_rsp_tid_i,
  input  logic [DataWidth-1:0]       mem_rsp_data_i,
  output logic [NrReq-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]       rsp_data_o,
  output logic [TidWidth:0]          outstanding_o,
  output logic                       err_o
);

  localparam int MaxTx = max_tx(TidWidth);
  localparam int IdxW  = (NrReq > 1) ? $clog2(NrReq) : 1;

  logic [MaxTx-1:0]    in_use, in_use_nx;
  logic [IdxW-1:0]     owner [MaxTx];
  logic                slot_free, tid_avail, arb_en, arb_any, grant, rsp_hit;
  logic [IdxW-1:0]     win;
  logic [NrReq-1:0]    gnt;
  logic [TidWidth-1:0] free_tid;
  logic [TidWidth:0]   pop_nx;

  assign slot_free = !mem_req_valid_o || mem_req_ready_i;
  assign tid_avail = ~&in_use;
  assign arb_en    = slot_free && tid_avail && !rst_i;
  assign grant     = arb_en && arb_any;

  rr_arbiter_ptr #(.NrReq(NrReq)) u_rr (
    .clk (clk_i),
    .rst (rst_i),
    .req (req_valid_i),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win),
    .any (arb_any)
  );

  assign req_ready_o = gnt;

  // Descending scan so the lowest free index wins.
  always_comb begin
    free_tid = '0;
    for (int t = MaxTx-1; t >= 0; t--) begin
      if (!in_use[t]) free_tid = TidWidth'(t);
    end
  end

  assign rsp_hit    = mem_rsp_valid_i && in_use[mem_rsp_tid_i];
  assign rsp_data_o = mem_rsp_data_i;

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_hit && !rst_i) rsp_valid_o[owner[mem_rsp_tid_i]] = 1'b1;
  end

  // The allocated TID is always free, so it never collides with the released one.
  always_comb begin
    in_use_nx = in_use;
    if (rsp_hit) in_use_nx[mem_rsp_tid_i] = 1'b0;
    if (grant)   in_use_nx[free_tid]      = 1'b1;
    pop_nx = '0;
    for (int t = 0; t < MaxTx; t++) pop_nx = pop_nx + (TidWidth+1)'(in_use_nx[t]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_tid_o   <= '0;
      in_use          <= '0;
      outstanding_o   <= '0;
      err_o           <= 1'b0;
      for (int t = 0; t < MaxTx; t++) owner[t] <= '0;
    end else begin
      in_use        <= in_use_nx;
      outstanding_o <= pop_nx;
      if (mem_rsp_valid_i && !in_use[mem_rsp_tid_i]) err_o <= 1'b1;
      if (grant) begin
        mem_req_valid_o <= 1'b1;
        mem_req_addr_o  <= req_addr_i[win*AddrWidth +: AddrWidth];
        mem_req_tid_o   <= free_tid;
        owner[free_tid] <= win;
      end else if (mem_req_ready_i) begin
        mem_req_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares the single cache-subsystem memory read channel between N requesters (icache refill, dcache refill, PTW), using round-robin arbitration.
- Allocates a transaction ID (TID) for each accepted request from a pool of 2**TidWidth entries, matching the configured memory TID width and maximum outstanding transactions.
- Routes out-of-order responses back to the requester that owns the TID, and sits between the cache requesters and the memory NoC adapter.

Parameters:
NrReq, 3, number of requesters (index 0 = icache, 1 = dcache, 2 = PTW by convention)
AddrWidth, 56, physical address width (PLEN)
DataWidth, 64, response data width
TidWidth, 2, memory TID width; pool size MaxTx = 2**TidWidth

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_valid_i  in  NrReq  per-requester read request valid
req_ready_o  out  NrReq  per-requester grant (one-hot or zero)
req_addr_i  in  NrReq*AddrWidth  packed request addresses, requester k at [k*AddrWidth +: AddrWidth]
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  AddrWidth  memory request address
mem_req_tid_o  out  TidWidth  allocated TID
mem_rsp_valid_i  in  1  memory response valid (always accepted)
mem_rsp_tid_i  in  TidWidth  response TID
mem_rsp_data_i  in  DataWidth  response data
rsp_valid_o  out  NrReq  one-hot response strobe to owning requester
rsp_data_o  out  DataWidth  shared response data bus
outstanding_o  out  TidWidth+1  number of TIDs in use
err_o  out  1  sticky: response received for an unallocated TID

Behaviour:
- Reset (async, rst_i=1) clears: output register empty (mem_req_valid_o=0, addr/tid=0); in_use bitmap=0; owner table=0; RR pointer=0; outstanding_o=0; err_o=0. req_ready_o and rsp_valid_o are 0 while in reset.
- Output register "slot" is free when empty, or when full with mem_req_ready_i=1 in the same cycle.
- Grant condition: slot free AND at least one TID free AND any req_valid_i set.
  - Winner = first valid index at or after RR pointer, wrapping modulo NrReq.
  - req_ready_o[winner]=1 combinationally; at most one bit is ever set.
- On grant (edge N):
  - slot loads addr and TID = lowest-index free TID;
  - in_use[TID] is set and owner[TID]=winner;
  - RR pointer becomes (winner+1) mod NrReq.
- mem_req_valid_o asserts at N+1, so request-to-memory latency is 1 cycle.
- mem_req_valid/addr/tid stay stable until mem_req_ready_i; valid is never dropped without ready.
- Back-to-back: with mem_req_ready_i held high and TIDs available, one request is issued per cycle.
- Response path is combinational:
  - rsp_valid_o[owner[mem_rsp_tid_i]] = mem_rsp_valid_i & in_use[mem_rsp_tid_i];
  - rsp_data_o = mem_rsp_data_i, unconditionally.
  - At the edge, in_use[tid] clears.
- A freed TID becomes allocatable the cycle after the response; same-cycle reuse of the freed TID is forbidden.
- Response with in_use[tid]=0: no rsp_valid_o, err_o sets and stays set until reset.
- TID allocation and release of a different TID in the same cycle are both honoured; outstanding_o is unchanged by that pair.
- outstanding_o = popcount(in_use), registered. TIDs are allocated at grant, so a slot-held request counts as outstanding.
- Pool exhausted (outstanding_o == MaxTx): all req_ready_o=0. Arbitration resumes the cycle after a release.
- Requesters may drop req_valid_i without a grant; no state is affected.
- Reset mid-operation discards all in-flight TIDs; responses arriving after reset for those TIDs set err_o.

Decomposition:
- Shared package (mem_arb_pkg): tid_t typedef, requester index constants (REQ_ICACHE/REQ_DCACHE/REQ_PTW), and the MaxTx localparam derivation.
- One sub-module, rr_arbiter_ptr: NrReq-wide round-robin picker with a registered pointer and async active-high reset.
- Lowest-free-TID selection and popcount are written inline.

Test Plan:
1. Reset, then req_valid_i=3'b001, addr 0x8000_0000, mem_req_ready_i=1 -> req_ready_o=001 same cycle; next cycle mem_req_valid_o=1, addr 0x8000_0000, tid 0; outstanding_o=1.
2. All three requesters valid continuously, ready=1, responses withheld -> grants in order 0,1,2,0 with TIDs 0,1,2,3; then req_ready_o=000 and outstanding_o=4.
3. From state 2, return response tid 2, data 0xDEAD_BEEF -> rsp_valid_o=100 (PTW), rsp_data_o=0xDEAD_BEEF; next cycle the pending grant gets tid 2.
4. mem_req_ready_i=0 for 5 cycles with a request in the slot -> valid/addr/tid stable throughout; no further grants; accepted on the 6th cycle.
5. Response tid 3 while in_use[3]=0 -> rsp_valid_o=000, err_o=1 and it stays 1.
6. Assert rst_i asynchronously with 2 outstanding -> all outputs go to 0 immediately; the next grant uses tid 0 and the RR pointer restarts at requester 0.
